mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//  Shares one memory port between two cache-style requesters (P0 = I-cache, P1 = D-cache).
//  Each requester issues single-cycle request pulses (rw_flag != 0) and expects a mem_done pulse carrying read data.
//  Latches each pulse into a per-port slot, picks a winner round-robin, issues the request to memory and routes mem_done back to the owner.
//  Sits between the two cache instances and the memory controller.
// PARAMETERS
//  LOCK_MAX  8  max consecutive grants to one port under burst lock (only used with MEM_ARB_BURST_LOCK_EN)
// PORTS
//  CLK             in   1   clock
//  RST             in   1   reset, asynchronous, active-high
//  pN_rw_flag      in   2   N=0,1; [0]=read, [1]=write; one-cycle pulse
//  pN_addr         in   32  request address (word aligned)
//  pN_write_data   in   32  write data
//  pN_write_mask   in   4   byte mask
//  pN_read_data    out  32  read data; valid while pN_done=1
//  pN_done         out  1   one-cycle completion pulse to port N
//  pN_busy         out  1   port N has a pending or in-service request
//  mem_rw_flag     out  2   one-cycle request pulse to memory
//  mem_addr        out  32  memory address
//  mem_write_data  out  32  memory write data
//  mem_write_mask  out  4   memory byte mask
//  mem_read_data   in   32  memory read data; valid with mem_done
//  mem_busy        in   1   memory busy (status only; no new issue while 1)
//  mem_done        in   1   memory completion pulse
//  err             out  1   sticky: request pulse arrived while that port's slot was occupied
// BEHAVIOUR
//  Reset: all outputs 0, slots empty, state IDLE, last_grant=1 (P0 wins first tie), lock count 0.
//  Slot: rw_flag!=0 at cycle t -> slot full from t+1; captures addr/data/mask. A pulse into a full slot is dropped and sets err.
//  States: IDLE, ISSUE, WAIT.
//   IDLE: if any slot full and !mem_busy -> ISSUE. Winner: the only full slot, or on a tie the port != last_grant.
//     Winner's slot fields load into the registered mem_* outputs. Winner's slot clears; owner <= winner; last_grant <= winner.
//   ISSUE: mem_rw_flag = owner's flag for exactly this cycle -> WAIT. All mem_* outputs return to 0 after ISSUE.
//   WAIT: on mem_done: pN_done=1 (combinational) for the owner only.
//     Next state is ISSUE if another slot is full (arbitrated as in IDLE) and !mem_busy, else IDLE.
//  pN_read_data = mem_read_data for the owner during mem_done, else 0.
//  Write requests complete with pN_done identically; read data is don't-care.
//  Latency: pulse at t -> mem_rw_flag at t+2 when idle; done is the same cycle as mem_done.
//  pN_busy = slot N full, or owner==N in ISSUE/WAIT.
//  Simultaneous pulse on a port and mem_done for that same port: accepted into the slot, not an error.
//   This is the back-to-back line-fill case.
//  Reset mid-transaction: everything is abandoned; no done is generated; a later stray mem_done in IDLE is ignored.
// CONFIGURATION
//  MEM_ARB_BURST_LOCK_EN defined:
//   In WAIT, when mem_done and the owner pulses a new request in the same cycle, the owner is re-granted ahead of the other port.
//   Limit: lock count < LOCK_MAX. Lock count increments on each re-grant and resets to 0 on a grant to the other port.
//   At LOCK_MAX the other port (if pending) wins.
//  Not defined: pure round-robin on every grant; lock counter absent.
// STRUCTURE
//  common.h: RW_READ=2'b01, RW_WRITE=2'b10, ARB_IDLE/ARB_ISSUE/ARB_WAIT encodings.
//  Sub-module mem_arb_slot (one per port): pending flag + captured addr/data/mask/rw; set/clear/err.
//  Top level: arbitration FSM, owner/last_grant/lock regs, output muxing.
// TESTING
//  1. Single read: P0 read 0x100 at t, done 3 cycles after issue.
//     -> mem_rw_flag=01, mem_addr=0x100 at t+2; p0_done with data 0xDEADBEEF; p1_done stays 0.
//  2. Simultaneous: P0 read 0x200 and P1 write 0x300/0x11223344/mask 0xF at the same t.
//     -> P0 issued first; P1 issued in the mem_done cycle's successor; P1 write sees mask 0xF.
//  3. Round-robin: both ports continuously re-request for 6 transactions (lock disabled).
//     -> grants alternate P0,P1,P0,P1,P0,P1.
//  4. Burst lock (MEM_ARB_BURST_LOCK_EN, LOCK_MAX=8): P0 8-word line fill while P1 is pending.
//     -> P0 gets 1 grant + 8 locked re-grants? No: 1 initial + re-grants until count=8, then P1 is served.
//     Check exact grant sequence.
//  5. Overflow: P1 pulses twice on consecutive cycles while a P0 transaction is in WAIT.
//     -> err=1 sticky; only the first P1 request is issued.
//  6. Reset: assert RST during WAIT.
//     -> all outputs 0 immediately; subsequent mem_done gives no pN_done; a new P1 request is served normally.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings, request record and arbitration helpers for the
// two-port memory arbiter (mem_arbiter, mem_arb_slot).
package mem_arbiter_pkg;

  // Request flag encodings carried on pN_rw_flag / mem_rw_flag.
  localparam logic [1:0] RW_READ  = 2'b01;
  localparam logic [1:0] RW_WRITE = 2'b10;

  // Arbitration FSM encodings.
  localparam logic [1:0] ARB_IDLE  = 2'b00;
  localparam logic [1:0] ARB_ISSUE = 2'b01;
  localparam logic [1:0] ARB_WAIT  = 2'b10;

  // One captured request: exactly what gets driven onto the memory port.
  typedef struct packed {
    logic [1:0]  rw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
  } mem_req_t;

  // A flag value counts as a request if either the read or write bit is set.
  function automatic logic is_req(input logic [1:0] rw);
    return |(rw & (RW_READ | RW_WRITE));
  endfunction

  // Round-robin pick between pending slots: the lone full slot wins,
  // a tie goes to the port that was not granted last.
  function automatic logic pick_winner(input logic [1:0] full, input logic last_grant);
    if (full == 2'b11) begin
      return ~last_grant;
    end
    return full[1];
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the two requester ports and the memory port of mem_arbiter.
// slave  = arbiter view, master = the surrounding caches + memory controller.
interface mem_arbiter_if;

  logic [1:0]  p0_rw_flag;
  logic [31:0] p0_addr;
  logic [31:0] p0_write_data;
  logic [3:0]  p0_write_mask;
  logic [31:0] p0_read_data;
  logic        p0_done;
  logic        p0_busy;

  logic [1:0]  p1_rw_flag;
  logic [31:0] p1_addr;
  logic [31:0] p1_write_data;
  logic [3:0]  p1_write_mask;
  logic [31:0] p1_read_data;
  logic        p1_done;
  logic        p1_busy;

  logic [1:0]  mem_rw_flag;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [3:0]  mem_write_mask;
  logic [31:0] mem_read_data;
  logic        mem_busy;
  logic        mem_done;

  logic        err;

  modport slave (
    input  p0_rw_flag, p0_addr, p0_write_data, p0_write_mask,
    output p0_read_data, p0_done, p0_busy,
    input  p1_rw_flag, p1_addr, p1_write_data, p1_write_mask,
    output p1_read_data, p1_done, p1_busy,
    output mem_rw_flag, mem_addr, mem_write_data, mem_write_mask,
    input  mem_read_data, mem_busy, mem_done,
    output err
  );

  modport master (
    output p0_rw_flag, p0_addr, p0_write_data, p0_write_mask,
    input  p0_read_data, p0_done, p0_busy,
    output p1_rw_flag, p1_addr, p1_write_data, p1_write_mask,
    input  p1_read_data, p1_done, p1_busy,
    input  mem_rw_flag, mem_addr, mem_write_data, mem_write_mask,
    output mem_read_data, mem_busy, mem_done,
    input  err
  );

endinterface

// File: rtl/mem_arb_slot.sv
// Per-port request slot: holds one pulsed request until the arbiter grants it.
// A pulse into an occupied slot is dropped and reported through err_pulse.
module mem_arb_slot
  import mem_arbiter_pkg::*;
(
  input  logic     CLK,
  input  logic     RST,
  input  logic     set_en,
  input  mem_req_t set_req,
  input  logic     clr,
  output logic     full,
  output mem_req_t req,
  output logic     err_pulse
);

  // A slot being granted this cycle is free for the next request, which is
  // what lets a cache chain line-fill beats back to back.
  logic occupied;

  assign occupied  = full && !clr;
  assign err_pulse = set_en && occupied;

  // Capture a request into a free slot; empty the slot when it is granted.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      full <= 1'b0;
      // NOTE: the payload is reset too so the memory port can never show stale
      // data after reset; it is a handful of flops, not a RAM array.
      req  <= '0;
    end else if (set_en && !occupied) begin
      // NOTE: sequential state always uses <= so every flop samples the
      // pre-edge value regardless of statement order.
      full <= 1'b1;
      req  <= set_req;
    end else if (clr) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: I-cache (P0) and D-cache (P1) share one memory port.
// Pulsed requests are held in per-port slots, granted round-robin, issued for a
// single cycle and the memory completion is routed back to the owning port.
// Optional feature: define MEM_ARB_BURST_LOCK_EN to let the current owner keep
// the port for up to LOCK_MAX back-to-back re-grants (line fills).
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned LOCK_MAX = 8
)(
  input  logic          CLK,
  input  logic          RST,
  mem_arbiter_if.slave  bus
);

  mem_req_t   pulse_req [2];
  mem_req_t   slot_req  [2];
  logic [1:0] slot_full;
  logic [1:0] slot_set;
  logic [1:0] slot_clr;
  logic [1:0] slot_err;

  logic [1:0] state_q, state_d;
  logic       owner_q;
  logic       last_grant_q;
  mem_req_t   mem_q;
  logic       err_q;

  logic       lock_hit;
  logic       can_arb;
  logic       do_grant;
  logic       grant_sel;
  mem_req_t   grant_req;
  logic       done_now;

  assign pulse_req[0] = '{rw: bus.p0_rw_flag, addr: bus.p0_addr,
                          wdata: bus.p0_write_data, mask: bus.p0_write_mask};
  assign pulse_req[1] = '{rw: bus.p1_rw_flag, addr: bus.p1_addr,
                          wdata: bus.p1_write_data, mask: bus.p1_write_mask};

  // A locked re-grant takes the owner's pulse straight to memory, so it must
  // not also land in the owner's slot.
  assign slot_set[0] = is_req(pulse_req[0].rw) && !(lock_hit && !owner_q);
  assign slot_set[1] = is_req(pulse_req[1].rw) && !(lock_hit &&  owner_q);
  assign slot_clr[0] = do_grant && !lock_hit && !grant_sel;
  assign slot_clr[1] = do_grant && !lock_hit &&  grant_sel;

  mem_arb_slot u_slot0 (
    .CLK       (CLK),
    .RST       (RST),
    .set_en    (slot_set[0]),
    .set_req   (pulse_req[0]),
    .clr       (slot_clr[0]),
    .full      (slot_full[0]),
    .req       (slot_req[0]),
    .err_pulse (slot_err[0])
  );

  mem_arb_slot u_slot1 (
    .CLK       (CLK),
    .RST       (RST),
    .set_en    (slot_set[1]),
    .set_req   (pulse_req[1]),
    .clr       (slot_clr[1]),
    .full      (slot_full[1]),
    .req       (slot_req[1]),
    .err_pulse (slot_err[1])
  );

`ifdef MEM_ARB_BURST_LOCK_EN
  localparam int unsigned LOCK_W = $clog2(LOCK_MAX + 1);

  logic [LOCK_W-1:0] lock_cnt_q;

  // Owner re-requests in its own completion cycle and still has lock budget.
  assign lock_hit = (state_q == ARB_WAIT) && bus.mem_done && !bus.mem_busy &&
                    is_req(pulse_req[owner_q].rw) &&
                    (lock_cnt_q < LOCK_W'(LOCK_MAX));

  // Count consecutive grants to the same port; a switch of port restarts it.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      lock_cnt_q <= '0;
    end else if (do_grant) begin
      if (grant_sel != last_grant_q) begin
        lock_cnt_q <= '0;
      end else if (lock_cnt_q < LOCK_W'(LOCK_MAX)) begin
        lock_cnt_q <= lock_cnt_q + 1'b1;
      end
    end
  end
`else
  assign lock_hit = 1'b0;
`endif

  // Grant decision: arbitration points are IDLE and the completion cycle in WAIT.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    can_arb   = 1'b0;
    grant_sel = pick_winner(slot_full, last_grant_q);
    if (!bus.mem_busy) begin
      can_arb = (state_q == ARB_IDLE) || ((state_q == ARB_WAIT) && bus.mem_done);
    end
    if (lock_hit) begin
      grant_sel = owner_q;
    end
    do_grant  = can_arb && (lock_hit || (|slot_full));
    grant_req = lock_hit ? pulse_req[owner_q] : slot_req[grant_sel];
  end

  // Next-state logic for the IDLE -> ISSUE -> WAIT cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE:  if (do_grant) state_d = ARB_ISSUE;
      ARB_ISSUE: state_d = ARB_WAIT;
      ARB_WAIT:  if (bus.mem_done) state_d = do_grant ? ARB_ISSUE : ARB_IDLE;
      default:   state_d = ARB_IDLE;
    endcase
  end

  // FSM, ownership and registered memory-port outputs (valid only in ISSUE).
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= ARB_IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      mem_q        <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q <= state_d;
      mem_q   <= do_grant ? grant_req : '0;
      if (do_grant) begin
        owner_q      <= grant_sel;
        last_grant_q <= grant_sel;
      end
      if (|slot_err) begin
        err_q <= 1'b1;
      end
    end
  end

  assign done_now = (state_q == ARB_WAIT) && bus.mem_done;

  assign bus.mem_rw_flag    = mem_q.rw;
  assign bus.mem_addr       = mem_q.addr;
  assign bus.mem_write_data = mem_q.wdata;
  assign bus.mem_write_mask = mem_q.mask;

  assign bus.p0_done      = done_now && !owner_q;
  assign bus.p1_done      = done_now &&  owner_q;
  assign bus.p0_read_data = bus.p0_done ? bus.mem_read_data : '0;
  assign bus.p1_read_data = bus.p1_done ? bus.mem_read_data : '0;
  assign bus.p0_busy      = slot_full[0] || (!owner_q && (state_q != ARB_IDLE));
  assign bus.p1_busy      = slot_full[1] || ( owner_q && (state_q != ARB_IDLE));
  assign bus.err          = err_q;

endmodule
